gpio_in_capture: RTL and testbench

GPIO_IN_CAPTURE -- requirements
Module: gpio_in_capture

---
 rtl/gpio_in_capture.sv | 117 +++++++++++
 tb/tb_gpio_in_capture.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/gpio_in_capture.sv
// GPIO header input capture: synchronize, debounce, edge latch, count.
// Define GPIO_IN_CAPTURE_FALL_EDGE_EN to make falling edges qualify too.
module gpio_in_capture #(
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 4
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic [31:0] GPIO,
    input  logic [1:0]  SEL,
    input  logic        CLR,
    output logic [9:0]  LEDR,
    output logic [7:0]  COUNT
);

    localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);
    localparam logic [2:0]  CNT_LAST   = 3'(STABLE_TICKS - 1);

    logic [31:0]      gpio_m_q;
    logic [31:0]      gpio_s_q;
    logic [15:0]      presc_q;
    logic [15:0]      presc_d;
    logic             tick;
    logic [31:0][2:0] cnt_q;
    logic [31:0][2:0] cnt_d;
    logic [31:0]      stable_q;
    logic [31:0]      stable_d;
    logic [31:0]      rise;
    logic [31:0]      qual;
    logic [31:0]      latch_q;
    logic [31:0]      latch_d;
    logic [7:0]       sel_qual;
    logic             hit;
    logic [7:0]       count_q;
    logic [7:0]       count_d;
    logic [9:0]       ledr_q;
    logic [9:0]       ledr_d;
    logic [4:0]       base;

    assign base = {SEL, 3'b000};

    // Sample tick prescaler, wraps at TICK_DIV-1.
    always_comb begin
        tick    = (presc_q == PRESC_LAST);
        presc_d = tick ? 16'd0 : presc_q + 16'd1;
    end

    // Per-bit debounce: count ticks of mismatch, flip level on the last one.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        for (int i = 0; i < 32; i++) begin
            if (gpio_s_q[i] == stable_q[i]) begin
                cnt_d[i] = 3'd0;
            end else if (tick) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = ~stable_q[i];
                    cnt_d[i]    = 3'd0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 3'd1;
                end
            end
        end
    end

    assign rise = stable_d & ~stable_q;

`ifdef GPIO_IN_CAPTURE_FALL_EDGE_EN
    logic [31:0] fall;
    assign fall = ~stable_d & stable_q;
    assign qual = rise | fall;
`else
    assign qual = rise;
`endif

    // Latches, edge counter and display image; an edge wins over CLR.
    always_comb begin
        sel_qual = qual[base +: 8];
        hit      = |sel_qual;
        latch_d  = CLR ? qual : (latch_q | qual);
        if (CLR) begin
            count_d = {7'd0, hit};
        end else if (hit && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end else begin
            count_d = count_q;
        end
        ledr_d = {|latch_q, |latch_q[base +: 8], stable_q[base +: 8]};
    end

    // State update; RESET overrides CLR and edges.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            gpio_m_q <= '0;
            gpio_s_q <= '0;
            presc_q  <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
            latch_q  <= '0;
            count_q  <= '0;
            ledr_q   <= '0;
        end else begin
            gpio_m_q <= GPIO;
            gpio_s_q <= gpio_m_q;
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            latch_q  <= latch_d;
            count_q  <= count_d;
            ledr_q   <= ledr_d;
        end
    end

    assign LEDR  = ledr_q;
    assign COUNT = count_q;

endmodule

// File: tb/tb_gpio_in_capture.sv
// Bench for gpio_in_capture: directed timing cases plus random phases
// checked against a settled-level model.
module tb_gpio_in_capture;

    localparam int TD = 4;
    localparam int ST = 3;

    logic        clk = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] GPIO = 32'hFFFF_FFFF;
    logic [1:0]  SEL = 2'b00;
    logic        CLR = 1'b0;
    logic [9:0]  LEDR;
    logic [7:0]  COUNT;

    int total = 0;
    int bad = 0;
    int n = 0;

    gpio_in_capture #(.TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
        .CLOCK_50(clk),
        .RESET(RESET),
        .GPIO(GPIO),
        .SEL(SEL),
        .CLR(CLR),
        .LEDR(LEDR),
        .COUNT(COUNT)
    );

    always #5 clk = ~clk;

    // Edges since the last reset edge; ticks land on edges n%TD==0, n>0.
    always @(posedge clk) begin
        if (RESET) n <= 0;
        else n <= n + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int t);
        while (n < t) step();
    endtask

    // Edge at which a pin change applied just after edge a is accepted.
    function automatic int flip_edge(input int a);
        int t1;
        t1 = ((a + 3 + TD - 1) / TD) * TD;
        return t1 + (ST - 1) * TD;
    endfunction

    logic [31:0] cur, nv, g, q, m_latch;
    logic [1:0]  msel;
    int          m_count, fe, len;
    logic [9:0]  exp_ledr;

    initial begin
        // Reset with all pins high, then watch the debounce window.
        step();
        chk("rst_ledr", 32'(LEDR), 32'd0);
        chk("rst_count", 32'(COUNT), 32'd0);
        RESET = 1'b0;
        run_to(11);
        chk("win_early", 32'(LEDR[7:0]), 32'h00);
        run_to(13);
        chk("win_late", 32'(LEDR[7:0]), 32'hFF);
        chk("win_count", 32'(COUNT), 32'd1);

        // Short pulse is rejected.
        GPIO = 32'd0;
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        GPIO = 32'h8;
        repeat (4) step();
        GPIO = 32'd0;
        repeat (20) step();
        chk("glitch_ledr", 32'(LEDR), 32'd0);
        chk("glitch_count", 32'(COUNT), 32'd0);

        // Byte 1 rise and fall.
        SEL = 2'b01;
        GPIO = 32'h200;
        repeat (20) step();
        chk("b9_rise_ledr", 32'(LEDR), 32'h302);
        chk("b9_rise_count", 32'(COUNT), 32'd1);
        GPIO = 32'd0;
        repeat (20) step();
        chk("b9_fall_ledr", 32'(LEDR), 32'h300);
`ifdef GPIO_IN_CAPTURE_FALL_EDGE_EN
        chk("b9_fall_count", 32'(COUNT), 32'd2);
`else
        chk("b9_fall_count", 32'(COUNT), 32'd1);
`endif

        // CLR in the very cycle rise[2] fires.
        SEL = 2'b00;
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        step();
        chk("clr_ledr", 32'(LEDR), 32'h000);
        chk("clr_count", 32'(COUNT), 32'd0);
        GPIO = 32'h4;
        fe = flip_edge(n);
        run_to(fe - 1);
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        step();
        chk("clr_edge_ledr", 32'(LEDR), 32'h304);
        chk("clr_edge_count", 32'(COUNT), 32'd1);

        // RESET with CLR and an edge in the same cycle, then requalify.
        GPIO = 32'h14;
        fe = flip_edge(n);
        run_to(fe - 1);
        RESET = 1'b1;
        CLR = 1'b1;
        step();
        chk("rst_edge_ledr", 32'(LEDR), 32'd0);
        chk("rst_edge_count", 32'(COUNT), 32'd0);
        RESET = 1'b0;
        CLR = 1'b0;
        repeat (20) step();
        chk("requal_ledr", 32'(LEDR), 32'h314);
        chk("requal_count", 32'(COUNT), 32'd1);

        // Saturation after 300 rising edges.
        GPIO = 32'd0;
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        for (int i = 0; i < 300; i++) begin
            GPIO = 32'h1;
            repeat (16) step();
            GPIO = 32'h0;
            repeat (16) step();
        end
        chk("sat_count", 32'(COUNT), 32'd255);
        chk("sat_ledr", 32'(LEDR), 32'h300);
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        step();
        chk("sat_clr_count", 32'(COUNT), 32'd0);
        chk("sat_clr_ledr", 32'(LEDR[9:8]), 32'd0);

        // Random phases against a settled-level model.
        cur = 32'd0;
        m_latch = 32'd0;
        m_count = 0;
        for (int ph = 0; ph < 40; ph++) begin
            msel = 2'($urandom_range(0, 3));
            SEL = msel;
            step();
            if ($urandom_range(0, 3) == 0) begin
                CLR = 1'b1;
                step();
                CLR = 1'b0;
                m_latch = 32'd0;
                m_count = 0;
            end
            g = $urandom;
            len = $urandom_range(1, (ST - 1) * TD);
            GPIO = cur ^ g;
            repeat (len) step();
            GPIO = cur;
            repeat (4) step();
            nv = cur ^ ($urandom & $urandom);
            GPIO = nv;
            repeat (18) step();
            q = nv & ~cur;
`ifdef GPIO_IN_CAPTURE_FALL_EDGE_EN
            q = q | (cur & ~nv);
`endif
            m_latch = m_latch | q;
            if ((q[msel*8 +: 8] != 8'd0) && (m_count < 255)) m_count++;
            cur = nv;
            exp_ledr = {|m_latch, |m_latch[msel*8 +: 8], cur[msel*8 +: 8]};
            chk("rnd_ledr", 32'(LEDR), 32'(exp_ledr));
            chk("rnd_count", 32'(COUNT), 32'(m_count));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
